// File: rtl/serial_comparator_framed.sv
// Serial magnitude comparator for framed operands.
// Operands A and B arrive DIGIT bits per accepted cycle. A frame is WIDTH/DIGIT
// digits, in MSB-first or LSB-first order. After the last digit of a frame,
// res_valid pulses for one cycle and the flags show the result. The flags then
// hold until the next result.
// Optional feature: define SERIAL_CMP_EARLY_DECIDE_EN to add the 'decided'
// output. It tells you that an MSB-first frame's result is already settled.
module serial_comparator_framed #(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 1,
    parameter int MSB_FIRST = 1,
    parameter int SIGNED    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             busy,
    output logic             res_valid,
    output logic             a_less_b,
    output logic             a_eq_b,
    output logic             a_greater_b
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
    ,
    output logic             decided
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_EQ = 2'd0,
        ST_LT = 2'd1,
        ST_GT = 2'd2
    } cmp_t;

    logic [CW-1:0] cnt;
    cmp_t          run;
    logic          last;
    logic          top;
    cmp_t          dig;
    cmp_t          nxt;

    // Compares one digit. In the digit that holds the word's sign bit, flipping
    // the top bit of both operands turns a two's-complement compare into an
    // unsigned one.
    function automatic cmp_t digit_cmp(input logic [DIGIT-1:0] x,
                                       input logic [DIGIT-1:0] y,
                                       input logic             negate_top);
        logic [DIGIT-1:0] xs;
        logic [DIGIT-1:0] ys;
        xs = x;
        ys = y;
        if (negate_top) begin
            xs[DIGIT-1] = ~x[DIGIT-1];
            ys[DIGIT-1] = ~y[DIGIT-1];
        end
        if (xs < ys) begin
            return ST_LT;
        end
        if (xs > ys) begin
            return ST_GT;
        end
        return ST_EQ;
    endfunction

    assign last = (cnt == LAST);
    assign top  = (SIGNED != 0) && ((MSB_FIRST != 0) ? (cnt == '0) : last);
    assign dig  = digit_cmp(a, b, top);
    assign busy = (cnt != '0);

    // Next running state.
    // MSB-first: the first differing digit decides the result.
    // LSB-first: the latest differing digit overrides earlier ones.
    always_comb begin
        nxt = run;
        if (MSB_FIRST != 0) begin
            if (run == ST_EQ) begin
                nxt = dig;
            end
        end else if (dig != ST_EQ) begin
            nxt = dig;
        end
    end

    // Digit counter, running state and registered result.
    // run returns to EQ at every frame boundary, so digit 0 always starts from EQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            run         <= ST_EQ;
            res_valid   <= 1'b0;
            a_less_b    <= 1'b0;
            a_eq_b      <= 1'b1;
            a_greater_b <= 1'b0;
        end else if (abort) begin
            cnt       <= '0;
            run       <= ST_EQ;
            res_valid <= 1'b0;
        end else if (in_valid) begin
            if (last) begin
                cnt         <= '0;
                run         <= ST_EQ;
                res_valid   <= 1'b1;
                a_less_b    <= (nxt == ST_LT);
                a_eq_b      <= (nxt == ST_EQ);
                a_greater_b <= (nxt == ST_GT);
            end else begin
                cnt       <= cnt + CW'(1);
                run       <= nxt;
                res_valid <= 1'b0;
            end
        end else begin
            res_valid <= 1'b0;
        end
    end

`ifdef SERIAL_CMP_EARLY_DECIDE_EN
    // decided goes high once an MSB-first frame has seen a differing digit.
    // It stays high through the result cycle.
    // It drops on an idle cycle when no frame is in progress.
    always_ff @(posedge clk) begin
        if (rst || abort || (MSB_FIRST == 0)) begin
            decided <= 1'b0;
        end else if (in_valid) begin
            decided <= (nxt != ST_EQ);
        end else if (cnt == '0) begin
            decided <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Testbench for serial_comparator_framed.
// Five instances cover different digit widths, digit orders and signedness.
// The reference model rebuilds whole words from the accepted digits and
// compares them arithmetically.
module tb_serial_comparator_framed;

    localparam int ND = 5;
    localparam int DW [ND] = '{1, 1, 2, 8, 4};
    localparam int MF [ND] = '{1, 1, 0, 1, 0};
    localparam int SG [ND] = '{0, 1, 0, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv   [ND];
    logic       abt  [ND];
    logic [7:0] da   [ND];
    logic [7:0] db   [ND];
    logic       o_busy [ND];
    logic       o_rv   [ND];
    logic       o_lt   [ND];
    logic       o_eq   [ND];
    logic       o_gt   [ND];
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
    logic       o_dec  [ND];
`endif

    int checks   = 0;
    int failures = 0;

    serial_comparator_framed #(.WIDTH(8), .DIGIT(1), .MSB_FIRST(1), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .abort(abt[0]), .in_valid(iv[0]),
        .a(da[0][0:0]), .b(db[0][0:0]), .busy(o_busy[0]), .res_valid(o_rv[0]),
        .a_less_b(o_lt[0]), .a_eq_b(o_eq[0]), .a_greater_b(o_gt[0])
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
        , .decided(o_dec[0])
`endif
    );
    serial_comparator_framed #(.WIDTH(8), .DIGIT(1), .MSB_FIRST(1), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .abort(abt[1]), .in_valid(iv[1]),
        .a(da[1][0:0]), .b(db[1][0:0]), .busy(o_busy[1]), .res_valid(o_rv[1]),
        .a_less_b(o_lt[1]), .a_eq_b(o_eq[1]), .a_greater_b(o_gt[1])
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
        , .decided(o_dec[1])
`endif
    );
    serial_comparator_framed #(.WIDTH(8), .DIGIT(2), .MSB_FIRST(0), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .abort(abt[2]), .in_valid(iv[2]),
        .a(da[2][1:0]), .b(db[2][1:0]), .busy(o_busy[2]), .res_valid(o_rv[2]),
        .a_less_b(o_lt[2]), .a_eq_b(o_eq[2]), .a_greater_b(o_gt[2])
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
        , .decided(o_dec[2])
`endif
    );
    serial_comparator_framed #(.WIDTH(8), .DIGIT(8), .MSB_FIRST(1), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst), .abort(abt[3]), .in_valid(iv[3]),
        .a(da[3]), .b(db[3]), .busy(o_busy[3]), .res_valid(o_rv[3]),
        .a_less_b(o_lt[3]), .a_eq_b(o_eq[3]), .a_greater_b(o_gt[3])
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
        , .decided(o_dec[3])
`endif
    );
    serial_comparator_framed #(.WIDTH(8), .DIGIT(4), .MSB_FIRST(0), .SIGNED(1)) u4 (
        .clk(clk), .rst(rst), .abort(abt[4]), .in_valid(iv[4]),
        .a(da[4][3:0]), .b(db[4][3:0]), .busy(o_busy[4]), .res_valid(o_rv[4]),
        .a_less_b(o_lt[4]), .a_eq_b(o_eq[4]), .a_greater_b(o_gt[4])
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
        , .decided(o_dec[4])
`endif
    );

    // Reference model state
    int         m_cnt  [ND];
    logic [7:0] m_a    [ND];
    logic [7:0] m_b    [ND];
    logic       m_rv   [ND];
    logic       m_lt   [ND];
    logic       m_eq   [ND];
    logic       m_gt   [ND];
    logic       m_diff [ND];
    logic       m_dec  [ND];

    function automatic int nd(input int k);
        return 8 / DW[k];
    endfunction

    function automatic logic [7:0] dmask(input int k);
        logic [7:0] m;
        m = '0;
        for (int j = 0; j < DW[k]; j++) m[j] = 1'b1;
        return m;
    endfunction

    function automatic int dpos(input int k, input int i);
        return (MF[k] == 1) ? (nd(k) - 1 - i) * DW[k] : i * DW[k];
    endfunction

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%b want=%b t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_a[k] = '0; m_b[k] = '0; m_rv[k] = 1'b0;
                m_lt[k] = 1'b0; m_eq[k] = 1'b1; m_gt[k] = 1'b0;
                m_diff[k] = 1'b0; m_dec[k] = 1'b0;
            end else if (abt[k]) begin
                m_cnt[k] = 0; m_rv[k] = 1'b0; m_diff[k] = 1'b0; m_dec[k] = 1'b0;
            end else if (iv[k]) begin
                logic [7:0] mk;
                int pos;
                int va;
                int vb;
                mk  = dmask(k);
                pos = dpos(k, m_cnt[k]);
                m_a[k] = (m_a[k] & ~(mk << pos)) | ((da[k] & mk) << pos);
                m_b[k] = (m_b[k] & ~(mk << pos)) | ((db[k] & mk) << pos);
                if ((da[k] & mk) != (db[k] & mk)) m_diff[k] = 1'b1;
                m_dec[k] = (MF[k] == 1) && m_diff[k];
                m_cnt[k]++;
                if (m_cnt[k] == nd(k)) begin
                    if (SG[k] == 1) begin
                        va = int'($signed(m_a[k]));
                        vb = int'($signed(m_b[k]));
                    end else begin
                        va = int'(m_a[k]);
                        vb = int'(m_b[k]);
                    end
                    m_lt[k] = (va < vb); m_eq[k] = (va == vb); m_gt[k] = (va > vb);
                    m_rv[k] = 1'b1; m_cnt[k] = 0; m_diff[k] = 1'b0;
                end else begin
                    m_rv[k] = 1'b0;
                end
            end else begin
                m_rv[k]  = 1'b0;
                m_dec[k] = (MF[k] == 1) && m_diff[k];
            end
        end
    endtask

    // Step the model at each rising edge, then compare every output just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("m_res_valid", k, o_rv[k], m_rv[k]);
            chk("m_busy", k, o_busy[k], (m_cnt[k] != 0));
            chk("m_lt", k, o_lt[k], m_lt[k]);
            chk("m_eq", k, o_eq[k], m_eq[k]);
            chk("m_gt", k, o_gt[k], m_gt[k]);
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
            chk("m_decided", k, o_dec[k], m_dec[k]);
`endif
        end
    end

    task automatic idle_all();
        for (int k = 0; k < ND; k++) begin
            iv[k] = 1'b0; abt[k] = 1'b0; da[k] = '0; db[k] = '0;
        end
    endtask

    task automatic put(input int k, input int i, input logic [7:0] av, input logic [7:0] bv);
        da[k]  = (av >> dpos(k, i)) & dmask(k);
        db[k]  = (bv >> dpos(k, i)) & dmask(k);
        iv[k]  = 1'b1;
        abt[k] = 1'b0;
    endtask

    // Drives one whole frame. With gaps set, an idle cycle goes before every
    // odd-numbered digit. Returns one cycle after the last digit, when the
    // result is visible. The last digit is still on the inputs at that point.
    task automatic frame(input int k, input logic [7:0] av, input logic [7:0] bv, input bit gaps);
        for (int i = 0; i < nd(k); i++) begin
            if (gaps && (i % 2 == 1)) begin
                iv[k] = 1'b0;
                @(negedge clk);
            end
            put(k, i, av, bv);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (3) @(negedge clk);
        chk("rst_eq", 0, o_eq[0], 1'b1);
        chk("rst_lt", 0, o_lt[0], 1'b0);
        chk("rst_busy", 0, o_busy[0], 1'b0);
        chk("rst_rv", 0, o_rv[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // A5 vs A3, MSB first, unsigned
        frame(0, 8'hA5, 8'hA3, 1'b0);
        chk("a5_a3_rv", 0, o_rv[0], 1'b1);
        chk("a5_a3_gt", 0, o_gt[0], 1'b1);
        iv[0] = 1'b0;
        @(negedge clk);
        chk("a5_a3_pulse_end", 0, o_rv[0], 1'b0);
        chk("a5_a3_hold", 0, o_gt[0], 1'b1);

        // 80 vs 01: unsigned greater, signed less
        frame(0, 8'h80, 8'h01, 1'b0);
        chk("u80_01_gt", 0, o_gt[0], 1'b1);
        iv[0] = 1'b0;
        frame(1, 8'h80, 8'h01, 1'b0);
        chk("s80_01_lt", 1, o_lt[1], 1'b1);
        iv[1] = 1'b0;

        // Single-digit frames: a result on every accepted digit
        put(3, 0, 8'h80, 8'h7F);
        @(negedge clk);
        chk("n1_rv", 3, o_rv[3], 1'b1);
        chk("n1_lt", 3, o_lt[3], 1'b1);
        chk("n1_busy", 3, o_busy[3], 1'b0);
        // An abort together with the only digit wins: no result, flags held
        put(3, 0, 8'h00, 8'hFF);
        abt[3] = 1'b1;
        @(negedge clk);
        chk("n1_abort_rv", 3, o_rv[3], 1'b0);
        chk("n1_abort_hold", 3, o_lt[3], 1'b1);
        abt[3] = 1'b0; iv[3] = 1'b0;

        // Signed, LSB first, 4-bit digits: -16 vs 16
        frame(4, 8'hF0, 8'h10, 1'b0);
        chk("lsb_signed_lt", 4, o_lt[4], 1'b1);
        iv[4] = 1'b0;

        // LSB first, 2-bit digits: equal frame with gaps, then a back-to-back frame
        frame(2, 8'h3C, 8'h3C, 1'b1);
        chk("eq_gaps_rv", 2, o_rv[2], 1'b1);
        chk("eq_gaps_eq", 2, o_eq[2], 1'b1);
        frame(2, 8'h12, 8'h21, 1'b0);
        chk("b2b_rv", 2, o_rv[2], 1'b1);
        chk("b2b_lt", 2, o_lt[2], 1'b1);
        iv[2] = 1'b0;

        // Abort after 5 digits, then a full frame
        frame(0, 8'h00, 8'h01, 1'b0);
        iv[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            put(0, i, 8'hFF, 8'h00);
            @(negedge clk);
        end
        put(0, 5, 8'hFF, 8'h00);
        abt[0] = 1'b1;
        @(negedge clk);
        chk("abort_rv", 0, o_rv[0], 1'b0);
        chk("abort_hold_lt", 0, o_lt[0], 1'b1);
        chk("abort_busy", 0, o_busy[0], 1'b0);
        abt[0] = 1'b0; iv[0] = 1'b0;
        @(negedge clk);
        frame(0, 8'h01, 8'h00, 1'b0);
        chk("after_abort_gt", 0, o_gt[0], 1'b1);
        iv[0] = 1'b0;
        @(negedge clk);

        // An abort on the 8th digit: no result
        for (int i = 0; i < 7; i++) begin
            put(0, i, 8'h00, 8'h00);
            @(negedge clk);
        end
        put(0, 7, 8'h00, 8'h01);
        abt[0] = 1'b1;
        @(negedge clk);
        chk("abort_last_rv", 0, o_rv[0], 1'b0);
        chk("abort_last_hold", 0, o_gt[0], 1'b1);
        abt[0] = 1'b0; iv[0] = 1'b0;

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) begin
            put(0, i, 8'hFF, 8'h00);
            @(negedge clk);
        end
        put(0, 4, 8'hFF, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_eq", 0, o_eq[0], 1'b1);
        chk("midrst_busy", 0, o_busy[0], 1'b0);
        rst = 1'b0; iv[0] = 1'b0;
        @(negedge clk);
        frame(0, 8'h10, 8'h20, 1'b0);
        chk("midrst_next_lt", 0, o_lt[0], 1'b1);
        iv[0] = 1'b0;
        @(negedge clk);

`ifdef SERIAL_CMP_EARLY_DECIDE_EN
        // 40 vs 00: digit 1 differs, so decided rises after digit 1 and stays up
        // through the result cycle
        for (int i = 0; i < 8; i++) begin
            put(0, i, 8'h40, 8'h00);
            @(negedge clk);
            chk("decided_trace", 0, o_dec[0], (i >= 1));
        end
        iv[0] = 1'b0;
        @(negedge clk);
        chk("decided_drop", 0, o_dec[0], 1'b0);
        chk("decided_lsb_zero", 2, o_dec[2], 1'b0);
`endif

        // Randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < ND; k++) begin
                logic [7:0] r;
                iv[k]  = ($urandom % 10) < 7;
                abt[k] = ($urandom % 40) == 0;
                da[k]  = 8'($urandom) & dmask(k);
                r      = 8'($urandom) & dmask(k);
                db[k]  = (($urandom % 10) < 6) ? da[k] : r;
            end
            rst = ($urandom % 250) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        idle_all();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_comparator_framed.md
SERIAL_COMPARATOR_FRAMED -- requirements
Module: serial_comparator_framed

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, total bits per compared word.
REQ-002 The block SHALL have parameter DIGIT, default 1, bits presented per accepted cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 means most significant digit first, 0 means least significant digit first.
REQ-004 The block SHALL have parameter SIGNED, default 0; 1 means two's-complement compare, 0 means unsigned compare.
REQ-005 Port clk, input, 1, clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port abort, input, 1, discards the frame in progress.
REQ-008 Port in_valid, input, 1, a and b carry a digit this cycle.
REQ-009 Port a, input, DIGIT, digit of operand A.
REQ-010 Port b, input, DIGIT, digit of operand B.
REQ-011 Port busy, output, 1, high while a frame is partially received.
REQ-012 Port res_valid, output, 1, one-cycle pulse marking a new result.
REQ-013 Ports a_less_b, a_eq_b, a_greater_b, outputs, 1 each, registered result, exactly one high after the first result.

Function
REQ-014 A frame SHALL be N = WIDTH/DIGIT accepted digits; a digit is accepted when in_valid=1, abort=0 and rst=0.
REQ-015 Cycles with in_valid=0 SHALL leave all frame state unchanged (gaps are allowed anywhere in a frame).
REQ-016 A digit counter SHALL count 0..N-1 and wrap to 0 after the Nth accepted digit.
REQ-017 MSB_FIRST=1: a running state in {EQ, LT, GT} SHALL start EQ at digit 0 and change only while EQ, taking the unsigned compare of the current digits.
REQ-018 MSB_FIRST=0: the running state SHALL be overwritten by the current digit compare whenever the digits differ, and kept when they are equal.
REQ-019 SIGNED=1: in the digit holding bit WIDTH-1 (digit 0 if MSB_FIRST=1, digit N-1 otherwise), that bit's weight SHALL be negated before comparing; the other bits remain unsigned.
REQ-020 The result SHALL be registered: on the cycle after the Nth accepted digit, res_valid=1 for one cycle and the three flags SHALL show the final state.
REQ-021 Flags SHALL hold their value until the next res_valid.
REQ-022 Back-to-back frames SHALL be supported: digit 0 of frame k+1 may be accepted in the cycle right after digit N-1 of frame k, with no lost digit.
REQ-023 busy SHALL be 1 when the counter is non-zero, else 0.
REQ-024 abort=1 SHALL reset the counter and the running state to EQ and drop any digit presented that cycle; result flags SHALL not change and res_valid SHALL stay 0.
REQ-025 If abort and the Nth digit arrive together, abort SHALL win and no result SHALL be produced.
REQ-026 N=1 SHALL work: every accepted digit produces a result the next cycle and busy stays 0.

Reset
REQ-027 On rst=1: counter=0, running state=EQ, busy=0, res_valid=0, a_eq_b=1, a_less_b=0, a_greater_b=0.
REQ-028 rst SHALL take priority over abort and in_valid; a reset mid-frame discards the partial frame without a result.

Configuration
REQ-029 Macro SERIAL_CMP_EARLY_DECIDE_EN SHALL add output decided (1 bit).
REQ-030 With SERIAL_CMP_EARLY_DECIDE_EN defined and MSB_FIRST=1, decided SHALL be 1 from the cycle after the first differing accepted digit of a frame until the cycle after that frame's last digit, and 0 otherwise. decided SHALL be 0 on reset or abort.
REQ-031 With the macro defined and MSB_FIRST=0, decided SHALL be held at 0.
REQ-032 Without the macro, the port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 WIDTH=8, DIGIT=1, MSB_FIRST=1: A=0xA5, B=0xA3 over 8 valid cycles -> res_valid next cycle, a_greater_b=1.
REQ-034 SIGNED=0 vs SIGNED=1: A=0x80, B=0x01 -> a_greater_b=1 unsigned, a_less_b=1 signed.
REQ-035 DIGIT=2, MSB_FIRST=0: A=0x3C, B=0x3C with in_valid gaps, then A=0x12, B=0x21 back-to-back -> a_eq_b=1, then a_less_b=1, two res_valid pulses.
REQ-036 Abort after 5 digits, then a full frame A=0x01, B=0x00 -> no pulse on abort, then a_greater_b=1 and prior flags held until then.
REQ-037 rst asserted at digit 4 -> flags go to eq=1, busy=0; the next full frame compares correctly.
REQ-038 Macro defined, A=0x40, B=0x00, MSB first -> decided=1 from cycle 3 until the cycle after digit 8.
